// File: rtl/priority_arbiter.sv
// Single-resource arbiter with a fixed-priority or round-robin search, a registered one-hot grant,
// and a hold-time watchdog that revokes a grant after TMO cycles.
module priority_arbiter #(
  parameter int N   = 8,
  parameter int RR  = 0,
  parameter int TMO = 255,
  localparam int W  = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         rel,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_idx,
  output logic         gnt_vld,
  output logic         tmo
);

  localparam logic [15:0] TMO_L = 16'(TMO);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       r_state;
  logic [N-1:0] r_gnt;
  logic [W-1:0] r_idx;
  logic         r_vld;
  logic         r_tmo;
  logic [W-1:0] r_last;
  logic [15:0]  r_cnt;

  logic [W-1:0] w_base;
  logic [W:0]   w_pos;
  logic [W-1:0] w_win_idx;
  logic         w_found;
  logic [N-1:0] w_win_onehot;
  logic         w_held;
  logic [15:0]  w_cnt_inc;

  // Fixed mode is the round-robin search with the pointer pinned at 0:
  // the order N-1 down to 0 then makes the highest set index win.
  assign w_base = (RR != 0) ? r_last : '0;

  always_comb begin
    w_pos     = '0;
    w_win_idx = '0;
    w_found   = 1'b0;
    for (int k = 1; k <= N; k++) begin
      w_pos = {1'b0, w_base} + (W+1)'(N - k);
      if (w_pos >= (W+1)'(N))
        w_pos = w_pos - (W+1)'(N);
      if (!w_found && req[w_pos[W-1:0]]) begin
        w_win_idx = w_pos[W-1:0];
        w_found   = 1'b1;
      end
    end
  end

  assign w_win_onehot = N'(1) << w_win_idx;
  assign w_held       = req[r_idx];
  assign w_cnt_inc    = r_cnt + 16'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_vld   <= 1'b0;
      r_tmo   <= 1'b0;
      r_last  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_tmo <= 1'b0;
          if (w_found) begin
            r_state <= BUSY;
            r_gnt   <= w_win_onehot;
            r_idx   <= w_win_idx;
            r_vld   <= 1'b1;
            r_last  <= w_win_idx;
            r_cnt   <= '0;
          end
        end
        BUSY: begin
          // A voluntary release outranks a coincident timeout, so tmo stays low.
          if (rel || !w_held || (w_cnt_inc == TMO_L)) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_vld   <= 1'b0;
            r_cnt   <= '0;
            r_tmo   <= !(rel || !w_held);
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = r_vld;
  assign tmo     = r_tmo;

endmodule

// File: tb/tb_priority_arbiter.sv
// Directed bench: a fixed-priority instance (TMO=4) and a round-robin instance share clock and reset.
module tb_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req_f, req_r;
  logic       rel_f, rel_r;
  logic [7:0] gnt_f, gnt_r;
  logic [2:0] idx_f, idx_r;
  logic       vld_f, vld_r, tmo_f, tmo_r;

  int total = 0;
  int bad   = 0;

  // Observation word: {gnt, gnt_idx, gnt_vld, tmo}
  wire [12:0] obs_f = {gnt_f, idx_f, vld_f, tmo_f};
  wire [12:0] obs_r = {gnt_r, idx_r, vld_r, tmo_r};

  always #5 clk = ~clk;

  priority_arbiter #(.N(8), .RR(0), .TMO(4)) dut_fix (
    .clk(clk), .rst(rst), .req(req_f), .rel(rel_f),
    .gnt(gnt_f), .gnt_idx(idx_f), .gnt_vld(vld_f), .tmo(tmo_f)
  );

  priority_arbiter #(.N(8), .RR(1), .TMO(255)) dut_rr (
    .clk(clk), .rst(rst), .req(req_r), .rel(rel_r),
    .gnt(gnt_r), .gnt_idx(idx_r), .gnt_vld(vld_r), .tmo(tmo_r)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [12:0] exp;
    rst = 1'b1; req_f = '0; req_r = '0; rel_f = 1'b0; rel_r = 1'b0;
    #2;
    exp = 13'h0;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL reset_fix: got %h want %h", obs_f, exp); end
    total++; if (obs_r !== exp) begin bad++; $display("FAIL reset_rr: got %h want %h", obs_r, exp); end
    tick; tick;
    rst = 1'b0;
    tick;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL idle_noreq_fix: got %h want %h", obs_f, exp); end
    total++; if (obs_r !== exp) begin bad++; $display("FAIL idle_noreq_rr: got %h want %h", obs_r, exp); end
    req_f = 8'h01;
    tick;
    exp = {8'h01, 3'd0, 1'b1, 1'b0};
    total++; if (obs_f !== exp) begin bad++; $display("FAIL first_arb: got %h want %h", obs_f, exp); end
    req_f = 8'h00;
    tick;
    exp = 13'h0;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL first_drop: got %h want %h", obs_f, exp); end
  endtask

  task automatic test_fixed;
    logic [12:0] exp;
    req_f = 8'b0010_0110;
    tick;
    exp = {8'h20, 3'd5, 1'b1, 1'b0};
    total++; if (obs_f !== exp) begin bad++; $display("FAIL fixed_win5: got %h want %h", obs_f, exp); end
    req_f = 8'b1010_0110;
    tick;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL fixed_hold: got %h want %h", obs_f, exp); end
    req_f = 8'b1000_0110;
    tick;
    exp = 13'h0;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL fixed_drop: got %h want %h", obs_f, exp); end
    tick;
    exp = {8'h80, 3'd7, 1'b1, 1'b0};
    total++; if (obs_f !== exp) begin bad++; $display("FAIL fixed_win7: got %h want %h", obs_f, exp); end
    rel_f = 1'b1;
    tick;
    exp = 13'h0;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL fixed_rel: got %h want %h", obs_f, exp); end
    rel_f = 1'b0; req_f = 8'h00;
    tick;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL fixed_idle: got %h want %h", obs_f, exp); end
  endtask

  task automatic test_drop_and_idle_rel;
    logic [12:0] exp;
    req_f = 8'h04;
    tick;
    exp = {8'h04, 3'd2, 1'b1, 1'b0};
    total++; if (obs_f !== exp) begin bad++; $display("FAIL drop_grant2: got %h want %h", obs_f, exp); end
    req_f = 8'h00;
    tick;
    exp = 13'h0;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL drop_release: got %h want %h", obs_f, exp); end
    rel_f = 1'b1;
    tick;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL rel_in_idle: got %h want %h", obs_f, exp); end
    rel_f = 1'b0; req_f = 8'h04;
    tick;
    exp = {8'h04, 3'd2, 1'b1, 1'b0};
    total++; if (obs_f !== exp) begin bad++; $display("FAIL both_grant2: got %h want %h", obs_f, exp); end
    req_f = 8'h00; rel_f = 1'b1;
    tick;
    exp = 13'h0;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL rel_and_drop: got %h want %h", obs_f, exp); end
    rel_f = 1'b0;
    tick;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL after_both: got %h want %h", obs_f, exp); end
  endtask

  task automatic test_timeout;
    logic [12:0] exp;
    req_f = 8'h08;
    exp = {8'h08, 3'd3, 1'b1, 1'b0};
    for (int c = 1; c <= 4; c++) begin
      tick;
      total++; if (obs_f !== exp) begin bad++; $display("FAIL tmo_hold_c%0d: got %h want %h", c, obs_f, exp); end
    end
    tick;
    exp = {8'h00, 3'd0, 1'b0, 1'b1};
    total++; if (obs_f !== exp) begin bad++; $display("FAIL tmo_pulse: got %h want %h", obs_f, exp); end
    tick;
    exp = {8'h08, 3'd3, 1'b1, 1'b0};
    total++; if (obs_f !== exp) begin bad++; $display("FAIL tmo_regrant: got %h want %h", obs_f, exp); end
    tick; tick; tick;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL tmo_hold2: got %h want %h", obs_f, exp); end
    rel_f = 1'b1;
    tick;
    exp = 13'h0;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL tmo_with_rel: got %h want %h", obs_f, exp); end
    rel_f = 1'b0; req_f = 8'h00;
    tick;
    total++; if (obs_f !== exp) begin bad++; $display("FAIL tmo_idle: got %h want %h", obs_f, exp); end
  endtask

  task automatic test_round_robin;
    logic [12:0] exp;
    logic [2:0]  seq [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    logic [7:0]  oh;
    req_r = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      tick;
      oh  = 8'h01 << seq[i];
      exp = {oh, seq[i], 1'b1, 1'b0};
      total++; if (obs_r !== exp) begin bad++; $display("FAIL rr_grant%0d: got %h want %h", i, obs_r, exp); end
      rel_r = 1'b1;
      tick;
      exp = 13'h0;
      total++; if (obs_r !== exp) begin bad++; $display("FAIL rr_idle%0d: got %h want %h", i, obs_r, exp); end
      rel_r = 1'b0;
    end
    req_r = 8'h81;
    tick;
    exp = {8'h01, 3'd0, 1'b1, 1'b0};
    total++; if (obs_r !== exp) begin bad++; $display("FAIL rr_wrap0: got %h want %h", obs_r, exp); end
    rel_r = 1'b1;
    tick;
    rel_r = 1'b0;
    tick;
    exp = {8'h80, 3'd7, 1'b1, 1'b0};
    total++; if (obs_r !== exp) begin bad++; $display("FAIL rr_wrap7: got %h want %h", obs_r, exp); end
    rel_r = 1'b1;
    tick;
    rel_r = 1'b0;
  endtask

  task automatic test_reset_busy;
    logic [12:0] exp;
    req_r = 8'hFF;
    tick;
    exp = {8'h40, 3'd6, 1'b1, 1'b0};
    total++; if (obs_r !== exp) begin bad++; $display("FAIL rstb_grant6: got %h want %h", obs_r, exp); end
    #2 rst = 1'b1;
    #1;
    exp = 13'h0;
    total++; if (obs_r !== exp) begin bad++; $display("FAIL rstb_async: got %h want %h", obs_r, exp); end
    tick;
    rst = 1'b0;
    tick;
    exp = {8'h80, 3'd7, 1'b1, 1'b0};
    total++; if (obs_r !== exp) begin bad++; $display("FAIL rstb_ptr_restart: got %h want %h", obs_r, exp); end
  endtask

  initial begin
    test_reset;
    test_fixed;
    test_drop_and_idle_rel;
    test_timeout;
    test_round_robin;
    test_reset_busy;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
